// File: rtl/dac_spi_tx_if.sv
// Sample handshake and DAC serial pins for dac_spi_tx.
// dac_ldac_n exists only when DAC_SPI_TX_LDAC_EN is defined.
interface dac_spi_tx_if;
    logic [7:0] dds_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_din;
    logic       busy;
`ifdef DAC_SPI_TX_LDAC_EN
    logic       dac_ldac_n;

    modport master (
        output dds_data, sample_valid,
        input  sample_ready, dac_cs_n, dac_sclk, dac_din, busy, dac_ldac_n
    );
    modport slave (
        input  dds_data, sample_valid,
        output sample_ready, dac_cs_n, dac_sclk, dac_din, busy, dac_ldac_n
    );
`else
    modport master (
        output dds_data, sample_valid,
        input  sample_ready, dac_cs_n, dac_sclk, dac_din, busy
    );
    modport slave (
        input  dds_data, sample_valid,
        output sample_ready, dac_cs_n, dac_sclk, dac_din, busy
    );
`endif
endinterface

// File: rtl/dac_spi_tx.sv
// Frames one 8-bit DDS sample per handshake MSB-first onto an SPI mode-0 DAC link.
// Optional load strobe dac_ldac_n enabled by defining DAC_SPI_TX_LDAC_EN.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned LEAD_BITS  = 4,
    parameter int unsigned TRAIL_BITS = 4,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dac_spi_tx_if.slave   io_dac
);
    localparam int unsigned FRAME_BITS = LEAD_BITS + 8 + TRAIL_BITS;
    localparam int unsigned PH_W       = $clog2(CLK_DIV) + 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS) + 1;
    localparam int unsigned GAP_W      = $clog2(CS_GAP) + 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [PH_W-1:0]       r_phase;
    logic [BIT_W-1:0]      r_bit;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_cs_n;
    logic                  r_sclk;
`ifdef DAC_SPI_TX_LDAC_EN
    logic                  r_ldac_n;
`endif

    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_accept;

    always_comb begin
        w_frame  = FRAME_BITS'(io_dac.dds_data) << TRAIL_BITS;
        w_accept = (r_state == S_IDLE) && io_dac.sample_valid && r_ready;
    end

    // dac_din is the shift register MSB; clearing the register drives din low in GAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_phase  <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
`ifdef DAC_SPI_TX_LDAC_EN
            r_ldac_n <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SHIFT;
                        r_shift <= w_frame;
                        r_phase <= '0;
                        r_bit   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (r_phase == PH_LAST) begin
                        r_state  <= S_GAP;
                        r_phase  <= '0;
                        r_bit    <= '0;
                        r_gap    <= '0;
                        r_shift  <= '0;
                        r_cs_n   <= 1'b1;
`ifdef DAC_SPI_TX_LDAC_EN
                        r_ldac_n <= 1'b0;
`endif
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end

                S_GAP: begin
`ifdef DAC_SPI_TX_LDAC_EN
                    r_ldac_n <= 1'b1;
`endif
                    if (r_gap == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_gap   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_shift <= '0;
                end
            endcase
        end
    end

    assign io_dac.sample_ready = r_ready;
    assign io_dac.busy         = r_busy;
    assign io_dac.dac_cs_n     = r_cs_n;
    assign io_dac.dac_sclk     = r_sclk;
    assign io_dac.dac_din      = r_shift[FRAME_BITS-1];
`ifdef DAC_SPI_TX_LDAC_EN
    assign io_dac.dac_ldac_n   = r_ldac_n;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default framing plus a CLK_DIV=1 / 8-bit-frame instance.
// Load-strobe checks are compiled in when DAC_SPI_TX_LDAC_EN is defined.
module tb_dac_spi_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    dac_spi_tx_if if0 ();
    dac_spi_tx_if if1 ();

    dac_spi_tx #(
        .CLK_DIV(4), .LEAD_BITS(4), .TRAIL_BITS(4), .CS_GAP(2)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .io_dac(if0)
    );

    dac_spi_tx #(
        .CLK_DIV(1), .LEAD_BITS(0), .TRAIL_BITS(0), .CS_GAP(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .io_dac(if1)
    );

    logic m_sel = 1'b0;
    logic m_ready, m_cs_n, m_sclk, m_din;
    assign m_ready = m_sel ? if1.sample_ready : if0.sample_ready;
    assign m_cs_n  = m_sel ? if1.dac_cs_n     : if0.dac_cs_n;
    assign m_sclk  = m_sel ? if1.dac_sclk     : if0.dac_sclk;
    assign m_din   = m_sel ? if1.dac_din      : if0.dac_din;

`ifdef DAC_SPI_TX_LDAC_EN
    int   ld0_low = 0, ld0_bad = 0, ld1_low = 0, ld1_bad = 0;
    logic pcs0 = 1'b1, pcs1 = 1'b1;
    always @(negedge clk) begin
        if (if0.dac_ldac_n === 1'b0) begin
            ld0_low++;
            if (!(if0.dac_cs_n === 1'b1 && pcs0 === 1'b0)) ld0_bad++;
        end
        if (if1.dac_ldac_n === 1'b0) begin
            ld1_low++;
            if (!(if1.dac_cs_n === 1'b1 && pcs1 === 1'b0)) ld1_bad++;
        end
        pcs0 = if0.dac_cs_n;
        pcs1 = if1.dac_cs_n;
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called on the first negedge after accept; returns at the first negedge with ready high.
    task automatic measure(input int budget, output logic [31:0] bits, output int nbits,
                           output int rlow, output int cslow, output int viol);
        logic ps, pd, pc;
        bits = '0; nbits = 0; rlow = 0; cslow = 0; viol = 0;
        ps = 1'b0; pd = m_din; pc = 1'b1;
        while (m_ready === 1'b0 && rlow < budget) begin
            rlow++;
            if (m_cs_n === 1'b0) cslow++;
            if (ps === 1'b0 && m_sclk === 1'b1) begin
                bits = {bits[30:0], m_din};
                nbits++;
            end
            if (pc === 1'b0 && m_cs_n === 1'b0 && m_din !== pd && !(ps === 1'b1 && m_sclk === 1'b0))
                viol++;
            ps = m_sclk; pd = m_din; pc = m_cs_n;
            step();
        end
    endtask

    logic [31:0] bits;
    int nbits, rlow, cslow, viol;
`ifdef DAC_SPI_TX_LDAC_EN
    int ld_before;
`endif

    initial begin
        rst_n = 1'b0;
        if0.dds_data = 8'h00; if0.sample_valid = 1'b0;
        if1.dds_data = 8'h00; if1.sample_valid = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_ready", if0.sample_ready, 1);
        chk("rst_busy",  if0.busy, 0);
        chk("rst_cs_n",  if0.dac_cs_n, 1);
        chk("rst_sclk",  if0.dac_sclk, 0);
        chk("rst_din",   if0.dac_din, 0);
        rst_n = 1'b1;
        step();

        // Single frame 0xA5
        if0.dds_data = 8'hA5; if0.sample_valid = 1'b1;
        step();
        if0.sample_valid = 1'b0;
        chk("a5_cs_low",   if0.dac_cs_n, 0);
        chk("a5_ready_lo", if0.sample_ready, 0);
        chk("a5_busy",     if0.busy, 1);
        chk("a5_din_msb",  if0.dac_din, 0);
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("a5_bits",   bits, 32'h0000_0A50);
        chk("a5_nbits",  nbits, 16);
        chk("a5_rlow",   rlow, 134);
        chk("a5_cslow",  cslow, 132);
        chk("a5_dinchg", viol, 0);
        chk("a5_idle",   if0.busy, 0);

        // Back-to-back 0x00, 0xFF, 0x80
        if0.dds_data = 8'h00; if0.sample_valid = 1'b1;
        step();
        if0.dds_data = 8'hFF;
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("b00_bits", bits, 32'h0000_0000);
        chk("b00_rlow", rlow, 134);
        chk("b00_gap",  rlow - cslow, 2);
        step();
        chk("bff_accept", if0.sample_ready, 0);
        if0.dds_data = 8'h80;
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("bff_bits", bits, 32'h0000_0FF0);
        chk("bff_rlow", rlow, 134);
        chk("bff_gap",  rlow - cslow, 2);
        chk("bff_dinchg", viol, 0);
        step();
        chk("b80_accept", if0.sample_ready, 0);
        if0.sample_valid = 1'b0;
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("b80_bits", bits, 32'h0000_0800);
        chk("b80_rlow", rlow, 134);
        chk("b80_gap",  rlow - cslow, 2);

        // Data change after accept; valid held through busy
        if0.dds_data = 8'h3C; if0.sample_valid = 1'b1;
        step();
        if0.dds_data = 8'hC3;
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("hold_bits", bits, 32'h0000_03C0);
        chk("hold_rlow", rlow, 134);

        // Frame 0xC3 starts; reset it during bit 7
        step();
        if0.sample_valid = 1'b0;
        chk("abort_started", if0.sample_ready, 0);
        repeat (58) step();
        chk("abort_mid_cs", if0.dac_cs_n, 0);
`ifdef DAC_SPI_TX_LDAC_EN
        ld_before = ld0_low;
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_cs_n",  if0.dac_cs_n, 1);
        chk("abort_sclk",  if0.dac_sclk, 0);
        chk("abort_din",   if0.dac_din, 0);
        chk("abort_ready", if0.sample_ready, 1);
        chk("abort_busy",  if0.busy, 0);
        step();
`ifdef DAC_SPI_TX_LDAC_EN
        chk("abort_no_ldac", ld0_low - ld_before, 0);
`endif
        if0.dds_data = 8'h5A; if0.sample_valid = 1'b1;
        step();
        if0.sample_valid = 1'b0;
        measure(300, bits, nbits, rlow, cslow, viol);
        chk("post_bits",  bits, 32'h0000_05A0);
        chk("post_nbits", nbits, 16);
        chk("post_rlow",  rlow, 134);

        // CLK_DIV=1, 8-bit frame, single-cycle gap
        m_sel = 1'b1;
        if1.dds_data = 8'h96; if1.sample_valid = 1'b1;
        step();
        if1.sample_valid = 1'b0;
        chk("d1_din_msb", if1.dac_din, 1);
        chk("d1_cs_low",  if1.dac_cs_n, 0);
        measure(100, bits, nbits, rlow, cslow, viol);
        chk("d1_bits",   bits, 32'h0000_0096);
        chk("d1_nbits",  nbits, 8);
        chk("d1_rlow",   rlow, 18);
        chk("d1_cslow",  cslow, 17);
        chk("d1_dinchg", viol, 0);
        m_sel = 1'b0;

        repeat (4) step();
`ifdef DAC_SPI_TX_LDAC_EN
        chk("ldac0_pulses", ld0_low, 6);
        chk("ldac0_align",  ld0_bad, 0);
        chk("ldac1_pulses", ld1_low, 1);
        chk("ldac1_align",  ld1_bad, 0);
        chk("ldac0_idle",   if0.dac_ldac_n, 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
